// File: rtl/strobe_stretch_n.sv
// strobe_stretch_n
//
// Multi-channel strobe stretcher. It turns mclk-synchronous strobes, which may be
// as short as one cycle, into pulses aligned to the reference edge of a slower
// sub_clk. Each pulse is PULSE_SUBCYCLES sub_clk periods wide. Strobes that arrive
// while a pulse is in progress are counted in a per-channel pending counter and
// replayed later. If that counter would overflow, the strobe is dropped and the
// sticky overflow flag is set.
//
// Ports:
//   mclk      in   master clock; all logic runs on its rising edge
//   reset     in   synchronous, active-high reset
//   sub_clk   in   slow clock, sampled as asynchronous data
//   strobe    in   [CHANNELS] per-channel event inputs (rising edge = one event)
//   clr_ovf   in   synchronous clear of all overflow bits
//   out       out  [CHANNELS] stretched pulses
//   busy      out  [CHANNELS] channel not idle, or events still pending
//   overflow  out  [CHANNELS] sticky: an event was dropped
module strobe_stretch_n #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned PULSE_SUBCYCLES = 2,
    parameter int unsigned PEND_W          = 3,
    parameter bit          EDGE            = 1'b0
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                sub_clk,
    input  logic [CHANNELS-1:0] strobe,
    input  logic                clr_ovf,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap
    } state_e;

    localparam logic [7:0]        CntLoad = 8'(PULSE_SUBCYCLES);
    localparam logic [PEND_W-1:0] PendMax = '1;

    // sub_clk synchroniser. s3 is only used for edge detection.
    logic s1_q, s2_q, s3_q;
    logic tick;

    always_ff @(posedge mclk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sub_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // One tick for all channels, on the selected reference edge.
    assign tick = EDGE ? (~s2_q & s3_q) : (s2_q & ~s3_q);

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        state_e            state_q, state_d;
        logic [7:0]        cnt_q, cnt_d;
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              str_q;
        logic              ovf_q, ovf_d;
        logic              ev;
        logic              start;

        // A strobe held high is a single event.
        assign ev = strobe[i] & ~str_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            start   = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tick && (pend_q != '0)) begin
                        state_d = StActive;
                        cnt_d   = CntLoad;
                        start   = 1'b1;
                    end
                end
                StActive: begin
                    if (tick) begin
                        if (cnt_q == 8'd1) begin
                            state_d = StGap;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                StGap: begin
                    // Guaranteed low period between back-to-back pulses.
                    if (tick) begin
                        if (pend_q != '0) begin
                            state_d = StActive;
                            cnt_d   = CntLoad;
                            start   = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // start only looks at the registered count, so an event arriving in a tick
        // cycle is never consumed by that same tick.
        always_comb begin
            pend_d = pend_q;
            ovf_d  = ovf_q;
            if (clr_ovf) begin
                ovf_d = 1'b0;
            end
            if (ev && !start) begin
                if (pend_q == PendMax) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end else if (start && !ev) begin
                pend_d = pend_q - 1'b1;
            end
        end

        always_ff @(posedge mclk) begin
            if (reset) begin
                state_q <= StIdle;
                cnt_q   <= 8'd0;
                pend_q  <= '0;
                str_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                str_q   <= strobe[i];
                ovf_q   <= ovf_d;
            end
        end

        assign out[i]      = (state_q == StActive);
        assign busy[i]     = (state_q != StIdle) || (pend_q != '0);
        assign overflow[i] = ovf_q;
    end

endmodule

// File: tb/tb_strobe_stretch_n.sv
// tb_strobe_stretch_n
//
// Directed bench for strobe_stretch_n. sub_clk runs at mclk/8 and toggles on the
// falling edge of mclk. One instance uses the default parameters. A second,
// single-channel instance uses EDGE=1 and PULSE_SUBCYCLES=1.
//
// Ports: none (top-level bench).
module tb_strobe_stretch_n;

    logic       mclk    = 1'b0;
    logic       reset   = 1'b1;
    logic       sub_clk = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] strobe  = '0;
    logic [3:0] out_m, busy_m, ovf_m;
    logic [0:0] strobe_f = '0;
    logic [0:0] out_f, busy_f, ovf_f;

    int cyc  = 0;
    int sdiv = 0;
    int n_cmp = 0;
    int n_err = 0;
    int npulse [4] = '{0, 0, 0, 0};
    int npulse_f   = 0;
    logic [3:0] prev_m = '0;
    logic       prev_f = 1'b0;

    strobe_stretch_n #(
        .CHANNELS       (4),
        .PULSE_SUBCYCLES(2),
        .PEND_W         (3),
        .EDGE           (1'b0)
    ) u_dut (
        .mclk    (mclk),
        .reset   (reset),
        .sub_clk (sub_clk),
        .strobe  (strobe),
        .clr_ovf (clr_ovf),
        .out     (out_m),
        .busy    (busy_m),
        .overflow(ovf_m)
    );

    strobe_stretch_n #(
        .CHANNELS       (1),
        .PULSE_SUBCYCLES(1),
        .PEND_W         (3),
        .EDGE           (1'b1)
    ) u_dut_f (
        .mclk    (mclk),
        .reset   (reset),
        .sub_clk (sub_clk),
        .strobe  (strobe_f),
        .clr_ovf (clr_ovf),
        .out     (out_f),
        .busy    (busy_f),
        .overflow(ovf_f)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    // sub_clk = mclk/8, changed away from the mclk rising edge.
    always @(negedge mclk) begin
        if (sdiv == 3) begin
            sdiv    <= 0;
            sub_clk <= ~sub_clk;
        end else begin
            sdiv <= sdiv + 1;
        end
    end

    // Count output rising edges per channel.
    always @(negedge mclk) begin
        for (int c = 0; c < 4; c++) begin
            if (out_m[c] === 1'b1 && prev_m[c] === 1'b0) npulse[c] = npulse[c] + 1;
        end
        if (out_f[0] === 1'b1 && prev_f === 1'b0) npulse_f = npulse_f + 1;
        prev_m = out_m;
        prev_f = out_f[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    function automatic logic sel_out(input bit fi, input int ch);
        return fi ? out_f[0] : out_m[ch];
    endfunction

    // Returns just after the first mclk edge that samples a rising (fall=0) or
    // falling (fall=1) sub_clk; k is that edge's number.
    task automatic sub_edge_sync(input bit fall, output int k);
        if (fall) @(negedge sub_clk);
        else      @(posedge sub_clk);
        @(posedge mclk);
        #1;
        k = cyc;
    endtask

    task automatic wait_level(input bit fi, input int ch, input logic val, input string tag);
        bit to = 1'b1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (sel_out(fi, ch) === val) begin
                to = 1'b0;
                break;
            end
        end
        chk({tag, "_timeout"}, 32'(to), 0);
    endtask

    task automatic wait_pulse(input bit fi, input int ch, input string tag,
                              output int rise, output int width);
        wait_level(fi, ch, 1'b1, {tag, "_rise"});
        rise = cyc;
        wait_level(fi, ch, 1'b0, {tag, "_fall"});
        width = cyc - rise;
    endtask

    task automatic wait_busy_low(input int ch, input int bound, input string tag,
                                 output int t);
        bit to = 1'b1;
        for (int n = 0; n < bound; n++) begin
            step();
            if (busy_m[ch] === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
        t = cyc;
        chk({tag, "_timeout"}, 32'(to), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r0, r1, r2, w0, w1, w2, t, snap0, snap3;

        // Reset state.
        repeat (3) step();
        chk("rst_out", 32'(out_m), 0);
        chk("rst_busy", 32'(busy_m), 0);
        chk("rst_ovf", 32'(ovf_m), 0);
        chk("rst_out_f", 32'(out_f), 0);
        reset = 1'b0;

        // Single strobe on ch0: tick for the next sub_clk rise (sampled at k+8)
        // moves the FSM at k+10.
        sub_edge_sync(1'b0, k);
        repeat (2) step();
        strobe[0] = 1'b1;
        step();
        strobe[0] = 1'b0;
        wait_pulse(1'b0, 0, "single", r0, w0);
        chk("single_rise", 32'(r0 - k), 10);
        chk("single_width", 32'(w0), 16);
        wait_busy_low(0, 40, "single_busy", t);
        chk("single_busy_fall", 32'(t - (r0 + w0)), 8);
        chk("single_count", 32'(npulse[0]), 1);
        chk("single_others", 32'(npulse[1] + npulse[2] + npulse[3]), 0);

        // Burst of three strobes on ch2, two cycles apart.
        sub_edge_sync(1'b0, k);
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            strobe[2] = 1'b1;
            step();
            strobe[2] = 1'b0;
            step();
        end
        wait_pulse(1'b0, 2, "burst0", r0, w0);
        wait_pulse(1'b0, 2, "burst1", r1, w1);
        wait_pulse(1'b0, 2, "burst2", r2, w2);
        chk("burst_rise0", 32'(r0 - k), 10);
        chk("burst_width0", 32'(w0), 16);
        chk("burst_width1", 32'(w1), 16);
        chk("burst_width2", 32'(w2), 16);
        chk("burst_space01", 32'(r1 - r0), 24);
        chk("burst_space12", 32'(r2 - r1), 24);
        wait_busy_low(2, 40, "burst_busy", t);
        chk("burst_count", 32'(npulse[2]), 3);
        chk("burst_ovf", 32'(ovf_m[2]), 0);

        // Saturation on ch1: nine strobes while a pulse is running.
        sub_edge_sync(1'b0, k);
        repeat (2) step();
        strobe[1] = 1'b1;
        step();
        strobe[1] = 1'b0;
        wait_level(1'b0, 1, 1'b1, "sat_first");
        for (int i = 0; i < 9; i++) begin
            strobe[1] = 1'b1;
            step();
            strobe[1] = 1'b0;
            step();
        end
        chk("sat_ovf_set", 32'(ovf_m[1]), 1);
        wait_busy_low(1, 400, "sat_busy", t);
        chk("sat_count", 32'(npulse[1]), 8);
        chk("sat_ovf_sticky", 32'(ovf_m[1]), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("sat_ovf_clr", 32'(ovf_m), 0);

        // Tick collision on ch3: the event coincides with the tick cycle.
        sub_edge_sync(1'b0, k);
        step();
        strobe[3] = 1'b1;
        step();
        strobe[3] = 1'b0;
        chk("coll_no_start", 32'(out_m[3]), 0);
        wait_pulse(1'b0, 3, "coll", r0, w0);
        chk("coll_rise", 32'(r0 - k), 10);

        // EDGE=1 / PULSE_SUBCYCLES=1 instance with a strobe held for several cycles.
        sub_edge_sync(1'b1, k);
        repeat (2) step();
        strobe_f = 1'b1;
        repeat (7) step();
        strobe_f = 1'b0;
        wait_pulse(1'b1, 0, "edge1", r0, w0);
        chk("edge1_rise", 32'(r0 - k), 10);
        chk("edge1_width", 32'(w0), 8);
        repeat (40) step();
        chk("edge1_count", 32'(npulse_f), 1);

        // Reset mid-pulse: ch0 has two events pending, ch3 has overflowed.
        sub_edge_sync(1'b0, k);
        repeat (2) step();
        for (int i = 0; i < 9; i++) begin
            strobe[3] = 1'b1;
            strobe[0] = (i < 3);
            step();
            strobe = '0;
            step();
        end
        chk("rmid_out_pre", 32'(out_m[0]), 1);
        chk("rmid_ovf_pre", 32'(ovf_m[3]), 1);
        reset = 1'b1;
        step();
        chk("rmid_out", 32'(out_m), 0);
        chk("rmid_busy", 32'(busy_m), 0);
        chk("rmid_ovf", 32'(ovf_m), 0);
        reset = 1'b0;
        snap0 = npulse[0];
        snap3 = npulse[3];
        repeat (100) step();
        chk("rmid_no_pulse0", 32'(npulse[0] - snap0), 0);
        chk("rmid_no_pulse3", 32'(npulse[3] - snap3), 0);
        chk("rmid_busy_after", 32'(busy_m), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
